// File: rtl/vending_pkg.sv
// Shared vending definitions: coin codes, cent values and controller states.
package vending_pkg;

  localparam int NUM_DENOMS = 6;

  localparam logic [2:0] COIN_NONE = 3'b000;
  localparam logic [2:0] COIN_1C   = 3'b001;
  localparam logic [2:0] COIN_5C   = 3'b010;
  localparam logic [2:0] COIN_10C  = 3'b011;
  localparam logic [2:0] COIN_25C  = 3'b100;
  localparam logic [2:0] COIN_50C  = 3'b101;
  localparam logic [2:0] COIN_100C = 3'b110;

  // Entry i holds the value of coin code i+1 (the same index as hopper_empty bit i).
  localparam logic [9:0] COIN_CENTS [NUM_DENOMS] = '{10'd1, 10'd5, 10'd10, 10'd25, 10'd50, 10'd100};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    REQUEST = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Cent value of a coin code; unused codes are worth nothing.
  function automatic logic [9:0] coin_value(input logic [2:0] code);
    if (code == COIN_NONE || code > COIN_100C) return 10'd0;
    return COIN_CENTS[code - 3'd1];
  endfunction

endpackage

// File: rtl/denom_picker.sv
// Picks the largest dispensable denomination that still fits the remaining amount.
module denom_picker
  import vending_pkg::*;
(
  input  logic [9:0] remaining,
  input  logic [5:0] hopper_empty,
  input  logic [5:0] jam,
  output logic       found,
  output logic [2:0] code
);

  // Scan upwards so that the last qualifying (largest) coin wins the priority.
  always_comb begin
    found = 1'b0;
    code  = COIN_NONE;
    for (int i = 0; i < NUM_DENOMS; i++) begin
      if (!hopper_empty[i] && !jam[i] && (coin_value(3'(i + 1)) <= remaining)) begin
        found = 1'b1;
        code  = 3'(i + 1);
      end
    end
  end

endmodule

// File: rtl/change_hopper_ctrl.sv
// Greedy change dispenser with a per-coin req/ack handshake and jam timeout.
module change_hopper_ctrl
  import vending_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMO_W          = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] amount_to_return,
  input  logic [5:0] hopper_empty,
  input  logic       coin_ack,
  output logic [2:0] coin_to_return,
  output logic       coin_req,
  output logic       busy,
  output logic       change_returned,
  output logic [9:0] shortfall,
  output logic       fault
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [9:0]       remaining_q, remaining_d;
  logic [5:0]       jam_q, jam_d;
  logic [2:0]       code_q, code_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             fault_q, fault_d;
  logic [9:0]       shortfall_q, shortfall_d;
  logic             pick_found;
  logic [2:0]       pick_code;

  denom_picker u_picker (
    .remaining    (remaining_q),
    .hopper_empty (hopper_empty),
    .jam          (jam_q),
    .found        (pick_found),
    .code         (pick_code)
  );

  // Register the FSM and its datapath; reset abandons any coin in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      jam_q       <= '0;
      code_q      <= COIN_NONE;
      tmo_q       <= '0;
      fault_q     <= 1'b0;
      shortfall_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      jam_q       <= jam_d;
      code_q      <= code_d;
      tmo_q       <= tmo_d;
      fault_q     <= fault_d;
      shortfall_q <= shortfall_d;
    end
  end

  // Next-state logic: select a coin, hand it to the hopper, wait out the ack.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    jam_d       = jam_q;
    code_d      = code_q;
    tmo_d       = tmo_q;
    fault_d     = fault_q;
    shortfall_d = shortfall_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = amount_to_return;
          jam_d       = '0;
          fault_d     = 1'b0;
          shortfall_d = '0;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        if (remaining_q == 10'd0) begin
          state_d = DONE;
        end else if (pick_found) begin
          code_d  = pick_code;
          tmo_d   = '0;
          state_d = REQUEST;
        end else begin
          shortfall_d = remaining_q;
          fault_d     = 1'b1;
          state_d     = DONE;
        end
      end
      REQUEST: begin
        if (coin_ack) begin
          remaining_d = remaining_q - coin_value(code_q);
          state_d     = RELEASE;
        end else if (tmo_q == TMO_LAST) begin
          jam_d[code_q - 3'd1] = 1'b1;
          fault_d              = 1'b1;
          state_d              = SELECT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!coin_ack) state_d = SELECT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign coin_req        = (state_q == REQUEST);
  assign coin_to_return  = (state_q == REQUEST) ? code_q : COIN_NONE;
  assign busy            = (state_q != IDLE);
  assign change_returned = (state_q == DONE);
  assign shortfall       = shortfall_q;
  assign fault           = fault_q;

endmodule

// File: tb/tb_change_hopper_ctrl.sv
// Directed scoreboard bench for change_hopper_ctrl with an auto-acking hopper model.
module tb_change_hopper_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] amount_to_return = '0;
  logic [5:0] hopper_empty = '0;
  logic       coin_ack = 1'b0;
  logic [2:0] coin_to_return;
  logic       coin_req;
  logic       busy;
  logic       change_returned;
  logic [9:0] shortfall;
  logic       fault;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] exp_q[$];
  int         len_q[$];
  logic [2:0] jam_code = 3'b000;
  logic       prev_req = 1'b0;
  int         cur_len  = 0;

  change_hopper_ctrl #(.TIMEOUT_CYCLES(8), .TMO_W(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .amount_to_return (amount_to_return),
    .hopper_empty     (hopper_empty),
    .coin_ack         (coin_ack),
    .coin_to_return   (coin_to_return),
    .coin_req         (coin_req),
    .busy             (busy),
    .change_returned  (change_returned),
    .shortfall        (shortfall),
    .fault            (fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Hopper model and scoreboard consumer: pops an expected code on each new request,
  // records request lengths, and acks immediately unless the code is the jammed one.
  initial begin
    forever begin
      @(negedge clock);
      if (coin_req && !prev_req) begin
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else check("coin_code", coin_to_return, exp_q.pop_front());
      end
      if (coin_req) cur_len++;
      else if (prev_req) begin
        len_q.push_back(cur_len);
        cur_len = 0;
      end
      coin_ack = coin_req && (coin_to_return != jam_code);
      prev_req = coin_req;
    end
  end

  task automatic applyStimulus(input logic [9:0] amount);
    len_q.delete();
    amount_to_return = amount;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    amount_to_return = 10'd999;
  endtask

  task automatic checkOutput(input string tag, input int budget,
                             input logic [9:0] exp_short, input logic exp_fault);
    for (int i = 0; i < budget; i++) begin
      if (change_returned) break;
      @(negedge clock);
    end
    check({tag, "_done"}, change_returned, 1);
    check({tag, "_shortfall"}, shortfall, exp_short);
    check({tag, "_fault"}, fault, exp_fault);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    @(negedge clock);
    check({tag, "_pulse_end"}, change_returned, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_req", coin_req, 0);
    check("rst_code", coin_to_return, 0);
    check("rst_busy", busy, 0);
    check("rst_done", change_returned, 0);
    check("rst_short", shortfall, 0);
    check("rst_fault", fault, 0);
    reset = 1'b0;
    @(negedge clock);

    // 41c, all hoppers full: 25 + 10 + 5 + 1
    $display("[TB] amount 41 greedy");
    exp_q = '{3'b100, 3'b011, 3'b010, 3'b001};
    applyStimulus(10'd41);
    check("t41_busy", busy, 1);
    checkOutput("t41", 100, 10'd0, 1'b0);
    check("t41_req_len", (len_q.size() > 0) ? len_q[0] : 0, 1);

    // 0c: completion two cycles after start, no coins
    $display("[TB] amount 0");
    applyStimulus(10'd0);
    check("t0_not_yet", change_returned, 0);
    @(negedge clock);
    check("t0_done_timing", change_returned, 1);
    @(negedge clock);
    check("t0_busy_drop", busy, 0);
    check("t0_no_coins", len_q.size(), 0);

    // 30c with the 25c hopper empty: three dimes
    $display("[TB] amount 30, 25c empty");
    hopper_empty = 6'b001000;
    exp_q = '{3'b011, 3'b011, 3'b011};
    applyStimulus(10'd30);
    checkOutput("t30", 100, 10'd0, 1'b0);
    hopper_empty = 6'b000000;

    // 7c with the 5c hopper jammed: timeout then seven pennies
    $display("[TB] amount 7, 5c jammed");
    jam_code = 3'b010;
    exp_q = '{3'b010, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    applyStimulus(10'd7);
    checkOutput("t7", 200, 10'd0, 1'b1);
    check("t7_jam_len", (len_q.size() > 0) ? len_q[0] : 0, 8);
    check("t7_coin_count", len_q.size(), 8);
    jam_code = 3'b000;

    // 3c with the 1c hopper empty: nothing dispensable
    $display("[TB] amount 3, 1c empty");
    hopper_empty = 6'b000001;
    applyStimulus(10'd3);
    checkOutput("t3", 50, 10'd3, 1'b1);
    check("t3_no_coins", len_q.size(), 0);
    hopper_empty = 6'b000000;

    // Reset while a 50c request is outstanding on 60c
    $display("[TB] reset mid-transaction");
    jam_code = 3'b101;
    exp_q = '{3'b101};
    applyStimulus(10'd60);
    for (int i = 0; i < 10; i++) begin
      if (coin_req) break;
      @(negedge clock);
    end
    check("tr_req_up", coin_req, 1);
    check("tr_req_code", coin_to_return, 3'b101);
    reset = 1'b1;
    @(negedge clock);
    check("tr_req", coin_req, 0);
    check("tr_code", coin_to_return, 0);
    check("tr_busy", busy, 0);
    check("tr_done", change_returned, 0);
    check("tr_short", shortfall, 0);
    check("tr_fault", fault, 0);
    reset = 1'b0;
    jam_code = 3'b000;
    @(negedge clock);
    check("tr_stay_idle", busy, 0);
    exp_q = '{3'b010};
    applyStimulus(10'd5);
    checkOutput("tr5", 100, 10'd0, 1'b0);
    check("tr5_coin_count", len_q.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/change_hopper_ctrl.md
# change_hopper_ctrl

Downstream consumer of the coin-return request produced by the vending controller. It takes a change amount in cents and dispenses it greedily as physical coins. For each coin it drives a request/acknowledge handshake to the coin hopper mechanics, skips empty or jammed hoppers, and reports completion, any undispensed shortfall, and faults. It replaces the free-running change-return path with a handshaked, timeout-protected one.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1000 — cycles coin_req may stay high without coin_ack before that hopper is declared jammed.
- TMO_W, 10 — width of the timeout counter; must satisfy 2^TMO_W ≥ TIMEOUT_CYCLES.

Ports:
- clock  in  1  — single clock; all state updates on rising edge.
- reset  in  1  — synchronous, active-high.
- start  in  1  — loads amount_to_return; honoured only in IDLE.
- amount_to_return  in  10  — change owed, unsigned cents, 0..1023.
- hopper_empty  in  6  — per-denomination empty flag: bit0=1c, bit1=5c, bit2=10c, bit3=25c, bit4=50c, bit5=100c.
- coin_ack  in  1  — hopper sensor; high once a coin has been ejected; held until coin_req drops.
- coin_to_return  out  3  — denomination code: 001=1c, 010=5c, 011=10c, 100=25c, 101=50c, 110=100c; 000 when no request.
- coin_req  out  1  — request one coin of coin_to_return.
- busy  out  1  — high in every state except IDLE.
- change_returned  out  1  — single-cycle completion pulse.
- shortfall  out  10  — undispensed cents; valid from change_returned until the next accepted start.
- fault  out  1  — a jam or shortfall occurred in the last transaction; cleared on the next accepted start.

Reset values: all outputs 0. The internal remaining register and the jam mask are both cleared.

## Operation
- States: IDLE, SELECT, REQUEST, RELEASE, DONE.
- IDLE: when start=1, load remaining←amount_to_return, clear the jam mask, clear fault and shortfall, then go to SELECT.
- SELECT:
  - If remaining==0, go to DONE.
  - Otherwise choose the largest denomination d with value(d) ≤ remaining, hopper_empty[d]=0, and jam[d]=0, then go to REQUEST with code latched.
  - If no such d exists: set shortfall←remaining and fault←1, then go to DONE.
  - hopper_empty is sampled only in SELECT.
- REQUEST:
  - coin_req=1 and coin_to_return=latched code. The timeout counter starts at 0 and increments each cycle.
  - If coin_ack=1: remaining←remaining−value(d), go to RELEASE.
  - If the counter reaches TIMEOUT_CYCLES−1 with coin_ack=0: set jam[d]←1 and fault←1, then go to SELECT.
  - If coin_ack and timeout occur in the same cycle, coin_ack wins.
- RELEASE: coin_req=0 and code=000. Wait for coin_ack=0, then go to SELECT. This prevents one long ack from being counted twice.
- DONE: change_returned=1 for one cycle, then go to IDLE.
- Subtraction never underflows, because selection guarantees value ≤ remaining. Width stays 10 bits.
- start outside IDLE is ignored. amount_to_return is sampled only on acceptance.
- Reset mid-transaction: abandon the transaction immediately (the pending coin is dropped), return to IDLE, all outputs 0 the following cycle, and no change_returned pulse.

## Timing
- Edge numbering: start is sampled at edge 0. SELECT runs in the cycle after edge 0. coin_req is first high after edge 1.
- amount 0: change_returned is high in the cycle after edge 1, and busy drops after edge 2.
- Per coin with immediate ack: coin_req high for 1 cycle, then RELEASE for ≥1 cycle, then SELECT for 1 cycle. This gives a minimum of 3 cycles per coin.
- Jam detection: coin_req is high for exactly TIMEOUT_CYCLES cycles, then the controller reselects.
- All outputs are registered-state decodes with no combinational path from inputs.

## Structure
- A shared package vending_pkg holds:
  - coin code constants (COIN_NONE, COIN_1C … COIN_100C);
  - the denomination count (6);
  - the cent value table and a coin_value(code) function;
  - the state typedef.
- One sub-module: denom_picker. It is combinational, takes remaining, hopper_empty and the jam mask, and outputs found plus code. It is a priority select from 100c down to 1c, and is shared with future restock logic.

## Test plan
- amount 41, all hoppers full, coin_ack one cycle after each coin_req → codes 100, 011, 010, 001 in order; change_returned pulse; shortfall=0; fault=0.
- amount 0 → change_returned high 2 cycles after start; coin_req never asserted.
- amount 30 with hopper_empty[3]=1 → codes 011, 011, 011; shortfall=0.
- amount 7, TIMEOUT_CYCLES=8, 5c hopper never acks → coin_req high for exactly 8 cycles on 010, fault=1, then 7× code 001; shortfall=0.
- amount 3 with hopper_empty[0]=1 → no coin_req; shortfall=3; fault=1; change_returned pulses.
- reset asserted while coin_req=1 and remaining=60 → next cycle all outputs 0, state IDLE; a subsequent start with amount 5 dispenses one 010 coin normally.
